// File: rtl/gen_keyer_pkg.sv
// Shared constants for the test-burst keyer: config register map, MODE bit
// positions, FSM state encoding and default widths.
package gen_keyer_pkg;

    localparam int DW_DEF    = 18;
    localparam int ENV_W_DEF = 17;
    localparam int CNT_W_DEF = 24;

    localparam logic [1:0] SEL_MODE      = 2'd0;
    localparam logic [1:0] SEL_ON_LEN    = 2'd1;
    localparam logic [1:0] SEL_OFF_LEN   = 2'd2;
    localparam logic [1:0] SEL_RAMP_STEP = 2'd3;

    localparam int MODE_EN   = 0;
    localparam int MODE_REP  = 1;
    localparam int MODE_MIX  = 2;
    localparam int MODE_BYP  = 3;
    localparam int MODE_TRIG = 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RAMP_UP   = 3'd1;
    localparam logic [2:0] ST_ON        = 3'd2;
    localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
    localparam logic [2:0] ST_OFF       = 3'd4;

endpackage

// File: rtl/gen_keyer_env.sv
// Burst envelope FSM: linear ramp up, hold, ramp down, gap, optional repeat.
// env_o is registered; burst_done_o pulses combinationally on the cycle env hits 0 in RAMP_DOWN.
module gen_keyer_env
    import gen_keyer_pkg::*;
#(
    parameter int ENV_W = ENV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             rep_i,
    input  logic             trig_i,
    input  logic [CNT_W-1:0] on_len_i,
    input  logic [CNT_W-1:0] off_len_i,
    input  logic [ENV_W-1:0] step_i,
    output logic [ENV_W-1:0] env_o,
    output logic             burst_done_o
);

    localparam logic [ENV_W-1:0] FULL = {1'b1, {(ENV_W-1){1'b0}}};

    logic [2:0]       state_q, state_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic [ENV_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [ENV_W-1:0] step_eff;
    logic [ENV_W:0]   up_sum;
    logic [ENV_W-1:0] up_env;
    logic [ENV_W-1:0] dn_env;

    assign step_eff = (step_i == '0) ? ENV_W'(1) : step_i;
    assign up_sum   = {1'b0, env_q} + {1'b0, step_q};
    assign up_env   = (up_sum >= {1'b0, FULL}) ? FULL : up_sum[ENV_W-1:0];
    assign dn_env   = (env_q > step_q) ? (env_q - step_q) : '0;

    // Step and durations are captured on state entry, so mid-burst writes land on the next phase.
    always_comb begin
        state_d      = state_q;
        env_d        = env_q;
        step_d       = step_q;
        cnt_d        = cnt_q;
        burst_done_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                env_d = '0;
                if (trig_i && en_i) begin
                    state_d = ST_RAMP_UP;
                    step_d  = step_eff;
                end
            end
            ST_RAMP_UP: begin
                if (!en_i) begin
                    state_d = ST_RAMP_DOWN;
                    step_d  = step_eff;
                end else begin
                    env_d = up_env;
                    if (up_env == FULL) begin
                        if (on_len_i == '0) begin
                            state_d = ST_RAMP_DOWN;
                            step_d  = step_eff;
                        end else begin
                            state_d = ST_ON;
                            cnt_d   = on_len_i;
                        end
                    end
                end
            end
            ST_ON: begin
                if (!en_i || cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RAMP_DOWN;
                    step_d  = step_eff;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RAMP_DOWN: begin
                env_d = dn_env;
                if (dn_env == '0) begin
                    burst_done_o = 1'b1;
                    if (en_i && off_len_i != '0) begin
                        state_d = ST_OFF;
                        cnt_d   = off_len_i;
                    end else if (en_i && rep_i) begin
                        state_d = ST_RAMP_UP;
                        step_d  = step_eff;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_OFF: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q <= CNT_W'(1)) begin
                    if (rep_i) begin
                        state_d = ST_RAMP_UP;
                        step_d  = step_eff;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                env_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            env_q   <= '0;
            step_q  <= ENV_W'(1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    assign env_o = env_q;

endmodule

// File: rtl/gen_keyer.sv
// Keys the generator sine with a ramped envelope and replaces or mixes it into the ADC stream.
// Fixed 3-cycle latency sample-in to rx_data; no backpressure, one sample per adc_clk.
module gen_keyer
    import gen_keyer_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int ENV_W = ENV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 adc_clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] gen_data,
    input  logic signed [DW-1:0] adc_data,
    input  logic                 cfg_wr,
    input  logic [1:0]           cfg_sel,
    input  logic [31:0]          cfg_data,
    output logic signed [DW-1:0] rx_data,
    output logic                 key_on,
    output logic [15:0]          burst_cnt
);

    localparam int               PW   = DW + ENV_W;
    localparam logic [ENV_W-1:0] FULL = {1'b1, {(ENV_W-1){1'b0}}};

    function automatic logic [DW-1:0] sat(input logic [DW:0] x);
        if (x[DW] != x[DW-1]) begin
            sat = {x[DW], {(DW-1){~x[DW]}}};
        end else begin
            sat = x[DW-1:0];
        end
    endfunction

    logic [3:0]       mode_q;
    logic             trig_q;
    logic [CNT_W-1:0] on_len_q;
    logic [CNT_W-1:0] off_len_q;
    logic [ENV_W-1:0] step_q;
    logic [CNT_W-1:0] len_sat;
    logic [ENV_W-1:0] step_sat;

    assign len_sat  = (|cfg_data[31:CNT_W]) ? '1 : cfg_data[CNT_W-1:0];
    assign step_sat = (cfg_data > 32'(FULL)) ? FULL : cfg_data[ENV_W-1:0];

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            mode_q    <= '0;
            trig_q    <= 1'b0;
            on_len_q  <= '0;
            off_len_q <= '0;
            step_q    <= ENV_W'(1);
        end else begin
            // TRIG is a write side effect only; it is never stored in MODE.
            trig_q <= cfg_wr && (cfg_sel == SEL_MODE) && cfg_data[MODE_TRIG];
            if (cfg_wr) begin
                case (cfg_sel)
                    SEL_MODE:    mode_q    <= cfg_data[3:0];
                    SEL_ON_LEN:  on_len_q  <= len_sat;
                    SEL_OFF_LEN: off_len_q <= len_sat;
                    default:     step_q    <= step_sat;
                endcase
            end
        end
    end

    logic [ENV_W-1:0] env;
    logic             burst_done;

    gen_keyer_env #(
        .ENV_W (ENV_W),
        .CNT_W (CNT_W)
    ) u_env (
        .clk_i        (adc_clk),
        .rst_i        (reset),
        .en_i         (mode_q[MODE_EN]),
        .rep_i        (mode_q[MODE_REP]),
        .trig_i       (trig_q),
        .on_len_i     (on_len_q),
        .off_len_i    (off_len_q),
        .step_i       (step_q),
        .env_o        (env),
        .burst_done_o (burst_done)
    );

    logic [15:0] burst_cnt_q;

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            burst_cnt_q <= '0;
        end else if (burst_done) begin
            burst_cnt_q <= burst_cnt_q + 16'd1;
        end
    end

    logic signed [DW-1:0] gen_s1_q, adc_s1_q, adc_s2_q;
    logic [ENV_W-1:0]     env_s1_q;
    logic signed [PW-1:0] prod_s2_q;
    logic                 nz_s2_q;
    logic signed [DW-1:0] rx_q;
    logic                 key_q;

    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] rnd;
    logic [DW:0]          scaled_w;
    logic [DW-1:0]        scaled;
    logic [DW:0]          sum_w;
    logic [DW-1:0]        rx_d;

    assign prod_d   = PW'(gen_s1_q) * PW'($signed({1'b0, env_s1_q}));
    assign rnd      = prod_s2_q + PW'(32768);
    assign scaled_w = rnd[PW-1:ENV_W-1];
    assign scaled   = sat(scaled_w);
    assign sum_w    = {adc_s2_q[DW-1], adc_s2_q} + {scaled[DW-1], scaled};

    always_comb begin
        rx_d = scaled;
        if (mode_q[MODE_BYP]) begin
            rx_d = adc_s2_q;
        end else if (mode_q[MODE_MIX]) begin
            rx_d = sat(sum_w);
        end
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            gen_s1_q  <= '0;
            adc_s1_q  <= '0;
            env_s1_q  <= '0;
            prod_s2_q <= '0;
            adc_s2_q  <= '0;
            nz_s2_q   <= 1'b0;
            rx_q      <= '0;
            key_q     <= 1'b0;
        end else begin
            gen_s1_q  <= gen_data;
            adc_s1_q  <= adc_data;
            env_s1_q  <= env;
            prod_s2_q <= prod_d;
            adc_s2_q  <= adc_s1_q;
            nz_s2_q   <= (env_s1_q != '0);
            rx_q      <= rx_d;
            key_q     <= nz_s2_q;
        end
    end

    logic cfg_unused;
    assign cfg_unused = ^{cfg_data[31:5], rnd[ENV_W-2:0]};

    assign rx_data   = rx_q;
    assign key_on    = key_q;
    assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_gen_keyer.sv
// Directed bench for gen_keyer: cycle tables for a single burst and the full-scale datapath,
// plus short sequences for repeat, disable, reset and bypass.
module tb_gen_keyer;
    import gen_keyer_pkg::*;

    localparam int DW = 18;

    logic                 adc_clk = 1'b0;
    logic                 reset   = 1'b1;
    logic signed [DW-1:0] gen_data = '0;
    logic signed [DW-1:0] adc_data = '0;
    logic                 cfg_wr   = 1'b0;
    logic [1:0]           cfg_sel  = '0;
    logic [31:0]          cfg_data = '0;
    logic signed [DW-1:0] rx_data;
    logic                 key_on;
    logic [15:0]          burst_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 adc_clk = ~adc_clk;

    gen_keyer dut (
        .adc_clk   (adc_clk),
        .reset     (reset),
        .gen_data  (gen_data),
        .adc_data  (adc_data),
        .cfg_wr    (cfg_wr),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .rx_data   (rx_data),
        .key_on    (key_on),
        .burst_cnt (burst_cnt)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  sel;
        logic [31:0] dat;
        int          gen;
        int          exp_rx;
        int          exp_key;
        int          exp_bcnt;
    } vec_t;

    typedef struct {
        logic mix;
        logic byp;
        int   gen;
        int   adc;
        int   exp_rx;
    } dp_t;

    vec_t                 t1[28];
    dp_t                  t3[8];
    logic signed [DW-1:0] hist[40];

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [31:0] d);
        cfg_wr   = 1'b1;
        cfg_sel  = sel;
        cfg_data = d;
        tick();
        cfg_wr   = 1'b0;
        cfg_data = '0;
    endtask

    task automatic do_reset();
        gen_data = '0;
        adc_data = '0;
        cfg_wr   = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int prev, cur, reached, exp_key;

        // Single burst: write at row 2, RAMP_UP from row 4, ON rows 8-17, RAMP_DOWN rows 18-21.
        // rx lags env by 3; the first RAMP_DOWN cycle still carries full scale.
        for (int i = 0; i < 28; i++) begin
            t1[i].wr       = 1'b0;
            t1[i].sel      = SEL_MODE;
            t1[i].dat      = '0;
            t1[i].gen      = 1000;
            t1[i].exp_rx   = (i >= 11 && i <= 21) ? 1000 : 0;
            t1[i].exp_key  = (i >= 8 && i <= 24) ? 1 : 0;
            t1[i].exp_bcnt = (i >= 22) ? 1 : 0;
        end
        t1[0].wr = 1'b1; t1[0].sel = SEL_ON_LEN;    t1[0].dat = 32'd10;
        t1[1].wr = 1'b1; t1[1].sel = SEL_RAMP_STEP; t1[1].dat = 32'd16384;
        t1[2].wr = 1'b1; t1[2].sel = SEL_MODE;      t1[2].dat = 32'h11;
        t1[8].exp_rx  = 250;
        t1[9].exp_rx  = 500;
        t1[10].exp_rx = 750;
        t1[22].exp_rx = 750;
        t1[23].exp_rx = 500;
        t1[24].exp_rx = 250;

        // Full-envelope datapath: replace, saturating mix, rounding and bypass.
        t3[0] = '{1'b0, 1'b0, 1000,    0,       1000};
        t3[1] = '{1'b0, 1'b0, -131072, 0,       -131072};
        t3[2] = '{1'b0, 1'b0, 131071,  0,       131071};
        t3[3] = '{1'b1, 1'b0, 1000,    131000,  131071};
        t3[4] = '{1'b1, 1'b0, -5,      -131072, -131072};
        t3[5] = '{1'b1, 1'b0, 300,     -500,    -200};
        t3[6] = '{1'b0, 1'b1, 777,     -12345,  -12345};
        t3[7] = '{1'b0, 1'b0, -1,      0,       -1};

        do_reset();
        check("reset_rx", rx_data, 0);
        check("reset_key", key_on, 0);
        check("reset_bcnt", burst_cnt, 0);
        check("reset_env", dut.u_env.env_q, 0);
        check("reset_state", dut.u_env.state_q, ST_IDLE);
        check("reset_step", dut.step_q, 1);

        for (int i = 0; i < 28; i++) begin
            check($sformatf("t1_rx[%0d]", i), rx_data, t1[i].exp_rx);
            check($sformatf("t1_key[%0d]", i), key_on, t1[i].exp_key);
            check($sformatf("t1_bcnt[%0d]", i), burst_cnt, t1[i].exp_bcnt);
            cfg_wr   = t1[i].wr;
            cfg_sel  = t1[i].sel;
            cfg_data = t1[i].dat;
            gen_data = DW'(t1[i].gen);
            tick();
        end
        cfg_wr = 1'b0;
        check("t1_idle", dut.u_env.state_q, ST_IDLE);

        // Repeat: 1 RAMP_UP + 4 ON + 1 RAMP_DOWN + 6 OFF = 12-cycle period, 5 keyed cycles each.
        do_reset();
        gen_data = 18'sd1000;
        cfg(SEL_ON_LEN, 32'd4);
        cfg(SEL_OFF_LEN, 32'd6);
        cfg(SEL_RAMP_STEP, 32'd65536);
        cfg(SEL_MODE, 32'h13);
        for (int j = 1; j <= 64; j++) begin
            exp_key = (j >= 6 && ((j - 6) % 12) < 5) ? 1 : 0;
            check($sformatf("t2_key[%0d]", j), key_on, exp_key);
            check($sformatf("t2_rx[%0d]", j), rx_data, exp_key * 1000);
            if (j == 55) check("t2_bcnt_4", burst_cnt, 4);
            if (j == 56) check("t2_bcnt_5", burst_cnt, 5);
            tick();
        end

        do_reset();
        cfg(SEL_ON_LEN, 32'd60000);
        cfg(SEL_RAMP_STEP, 32'd65536);
        cfg(SEL_MODE, 32'h11);
        repeat (6) tick();
        for (int i = 0; i < 8; i++) begin
            gen_data = DW'(t3[i].gen);
            adc_data = DW'(t3[i].adc);
            cfg(SEL_MODE, {28'd0, t3[i].byp, t3[i].mix, 2'b01});
            repeat (3) tick();
            check($sformatf("t3_rx[%0d]", i), rx_data, t3[i].exp_rx);
            check($sformatf("t3_key[%0d]", i), key_on, 1);
        end
        adc_data = '0;

        // EN cleared mid-ON: ramp down from the next cycle in 125-LSB steps.
        do_reset();
        gen_data = 18'sd1000;
        cfg(SEL_ON_LEN, 32'd20);
        cfg(SEL_RAMP_STEP, 32'd8192);
        cfg(SEL_MODE, 32'h11);
        repeat (14) tick();
        cfg(SEL_MODE, 32'h0);
        check("t4_still_on", dut.u_env.state_q, ST_ON);
        tick();
        check("t4_rampdown_next", dut.u_env.state_q, ST_RAMP_DOWN);
        check("t4_rx_full", rx_data, 1000);
        prev    = rx_data;
        reached = 0;
        for (int k = 0; k < 30 && reached == 0; k++) begin
            tick();
            cur = rx_data;
            check($sformatf("t4_decay[%0d]", k), (cur <= prev && prev - cur <= 125) ? 1 : 0, 1);
            prev = cur;
            if (cur == 0) reached = 1;
        end
        check("t4_reached_zero", reached, 1);
        check("t4_bcnt", burst_cnt, 1);

        // Reset mid-RAMP_UP, then TRIG without EN is ignored.
        do_reset();
        gen_data = 18'sd1000;
        cfg(SEL_RAMP_STEP, 32'd1024);
        cfg(SEL_MODE, 32'h11);
        repeat (10) tick();
        check("t5_in_rampup", dut.u_env.state_q, ST_RAMP_UP);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_env_zero", dut.u_env.env_q, 0);
        check("t5_idle", dut.u_env.state_q, ST_IDLE);
        repeat (3) tick();
        check("t5_rx_zero", rx_data, 0);
        check("t5_key_zero", key_on, 0);
        cfg(SEL_MODE, 32'h10);
        repeat (3) tick();
        check("t5_trig_ignored", dut.u_env.state_q, ST_IDLE);
        check("t5_key_still_zero", key_on, 0);
        cfg(SEL_MODE, 32'h11);
        tick();
        check("t5_retrig", dut.u_env.state_q, ST_RAMP_UP);

        // Bypass: rx_data is adc_data three samples late, regardless of gen.
        do_reset();
        cfg(SEL_MODE, 32'h08);
        for (int i = 0; i < 40; i++) begin
            if (i >= 3) check($sformatf("t6_byp[%0d]", i), rx_data, hist[i-3]);
            adc_data = DW'($urandom);
            gen_data = DW'($urandom);
            hist[i]  = adc_data;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
